// File: rtl/rv32i_pkg.sv
// rv32i_pkg: shared RV32I register-file widths, types and the read-port priority function.
package rv32i_pkg;
    localparam int AW   = 5;
    localparam int XLEN = 32;
    localparam int NREG = 2 ** AW;
    typedef logic [AW-1:0]   reg_addr_t;
    typedef logic [XLEN-1:0] word_t;
    localparam reg_addr_t REG_ZERO = 5'd0;
    // x0 reads zero even while a same-address write is being bypassed
    function automatic word_t rd_sel(input reg_addr_t a, input logic byp, input word_t wd, input word_t q);
        return (a == REG_ZERO) ? '0 : byp ? wd : q;
    endfunction
endpackage

// File: rtl/reg_file_wb_if.sv
// reg_file_wb_if: write-back and read-port signals of the register file.
interface reg_file_wb_if;
    import rv32i_pkg::*;
    logic      we;
    reg_addr_t rd_addr;
    word_t     rd_data;
    reg_addr_t rs1_addr;
    reg_addr_t rs2_addr;
    word_t     rs1_data;
    word_t     rs2_data;
    logic      wr_valid;
    reg_addr_t wr_addr_q;
    modport master (output we, rd_addr, rd_data, rs1_addr, rs2_addr,
                    input  rs1_data, rs2_data, wr_valid, wr_addr_q);
    modport slave  (input  we, rd_addr, rd_data, rs1_addr, rs2_addr,
                    output rs1_data, rs2_data, wr_valid, wr_addr_q);
endinterface

// File: rtl/wb_demux.sv
// wb_demux: decodes the write-back destination into a one-hot enable with x0 masked.
module wb_demux
    import rv32i_pkg::*;
(
    input  logic            i_we,
    input  reg_addr_t       i_rd_addr,
    output logic [NREG-1:0] o_en
);
    always_comb begin
        o_en = '0;
        o_en[i_rd_addr] = i_we;
        o_en[REG_ZERO] = 1'b0;
    end
endmodule

// File: rtl/reg_file_wb.sv
// reg_file_wb: RV32I register file, two async read ports, one write port, x0 zero, write-through bypass.
module reg_file_wb
    import rv32i_pkg::*;
#(
    parameter word_t RESET_VAL = '0
)
(
    input logic           clk,
    input logic           rst_n,
    reg_file_wb_if.slave  bus
);
    logic [NREG-1:0] w_en;
    word_t           w_file [NREG];
    logic            r_wr_valid;
    reg_addr_t       r_wr_addr;
    // a write held in reset is dropped, so it must not be bypassed either
    wb_demux u_demux (
        .i_we      (bus.we & rst_n),
        .i_rd_addr (bus.rd_addr),
        .o_en      (w_en)
    );
    assign w_file[0] = '0;
    for (genvar i = 1; i < NREG; i++) begin : g_reg
        word_t r_q;
        always_ff @(posedge clk or negedge rst_n)
            if (!rst_n) r_q <= RESET_VAL;
            else if (w_en[i]) r_q <= bus.rd_data;
        assign w_file[i] = r_q;
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            r_wr_valid <= 1'b0;
            r_wr_addr  <= '0;
        end else begin
            r_wr_valid <= |w_en;
            r_wr_addr  <= bus.rd_addr;
        end
    assign bus.rs1_data  = rd_sel(bus.rs1_addr, w_en[bus.rs1_addr], bus.rd_data, w_file[bus.rs1_addr]);
    assign bus.rs2_data  = rd_sel(bus.rs2_addr, w_en[bus.rs2_addr], bus.rd_data, w_file[bus.rs2_addr]);
    assign bus.wr_valid  = r_wr_valid;
    assign bus.wr_addr_q = r_wr_addr;
endmodule

// File: tb/tb_reg_file_wb.sv
// tb_reg_file_wb: directed and random checks of reg_file_wb against a storage/bypass/x0 model.
module tb_reg_file_wb;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        we = 1'b0;
    logic [4:0]  rd_addr = '0;
    logic [31:0] rd_data = '0;
    logic [4:0]  rs1_addr = '0;
    logic [4:0]  rs2_addr = '0;
    logic [31:0] m_regs [32];
    logic        m_valid;
    logic [4:0]  m_addr;
    int          n_cmp = 0;
    int          n_bad = 0;

    reg_file_wb_if bus ();
    assign bus.we       = we;
    assign bus.rd_addr  = rd_addr;
    assign bus.rd_data  = rd_data;
    assign bus.rs1_addr = rs1_addr;
    assign bus.rs2_addr = rs2_addr;

    reg_file_wb dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    always @(posedge clk)
        if (rst_n) assert (!$isunknown(we)) else begin
            n_bad++;
            $error("FAIL we_known: got %b want 0/1", we);
        end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_rd(input logic [4:0] a);
        if (a == 5'd0) return '0;
        if (rst_n && we && rd_addr != 5'd0 && a == rd_addr) return rd_data;
        return m_regs[a];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        m_valid = 1'b0;
        m_addr  = '0;
    endtask

    // commit the current inputs at the next rising edge, then settle 1 time unit
    task automatic tick();
        @(posedge clk);
        if (rst_n) begin
            if (we && rd_addr != 5'd0) m_regs[rd_addr] = rd_data;
            m_valid = we && rd_addr != 5'd0;
            m_addr  = rd_addr;
        end
        #1;
    endtask

    task automatic check_echo(input string tag);
        check({tag, "_wr_valid"}, {31'd0, bus.wr_valid}, {31'd0, m_valid});
        if (m_valid) check({tag, "_wr_addr_q"}, {27'd0, bus.wr_addr_q}, {27'd0, m_addr});
    endtask

    initial begin
        model_reset();
        tick();
        tick();
        for (int a = 0; a < 32; a++) begin
            rs1_addr = 5'(a);
            #0.1;
            check("reset_rs1", bus.rs1_data, 32'h0);
        end
        check("reset_wr_valid", {31'd0, bus.wr_valid}, 32'h0);
        rst_n = 1'b1;

        we = 1'b1; rd_addr = 5'd5; rd_data = 32'hDEADBEEF;
        tick();
        check("basic_wr_valid", {31'd0, bus.wr_valid}, 32'h1);
        check("basic_wr_addr_q", {27'd0, bus.wr_addr_q}, 32'd5);
        we = 1'b0; rs1_addr = 5'd5;
        #1;
        check("basic_rs1", bus.rs1_data, 32'hDEADBEEF);

        we = 1'b1; rd_addr = 5'd0; rd_data = 32'hFFFFFFFF; rs2_addr = 5'd0;
        #1;
        check("x0_same_cycle", bus.rs2_data, 32'h0);
        tick();
        check("x0_wr_valid", {31'd0, bus.wr_valid}, 32'h0);
        we = 1'b0;
        #1;
        check("x0_after", bus.rs2_data, 32'h0);

        we = 1'b1; rd_addr = 5'd7; rd_data = 32'h1;
        tick();
        rd_data = 32'h2; rs1_addr = 5'd7; rs2_addr = 5'd7;
        #1;
        check("bypass_rs1_pre", bus.rs1_data, 32'h2);
        check("bypass_rs2_pre", bus.rs2_data, 32'h2);
        tick();
        we = 1'b0;
        #1;
        check("bypass_rs1_post", bus.rs1_data, 32'h2);
        check("bypass_rs2_post", bus.rs2_data, 32'h2);
        check_echo("bypass");

        we = 1'b1; rd_addr = 5'd9; rd_data = 32'h55;
        tick();
        rd_data = 32'h66; rs1_addr = 5'd9; rs2_addr = 5'd5;
        #1;
        check("async_bypass", bus.rs1_data, 32'h66);
        #1;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("async_rs1_x9", bus.rs1_data, 32'h0);
        check("async_rs2_x5", bus.rs2_data, 32'h0);
        check("async_wr_valid", {31'd0, bus.wr_valid}, 32'h0);
        tick();
        we = 1'b0;
        rst_n = 1'b1;
        #1;
        check("async_dropped", bus.rs1_data, 32'h0);
        check("async_wr_valid_rel", {31'd0, bus.wr_valid}, 32'h0);
        we = 1'b1; rd_data = 32'h77;
        tick();
        we = 1'b0;
        #1;
        check("first_after_rst", bus.rs1_data, 32'h77);
        check_echo("first_after_rst");

        for (int k = 0; k < 10000; k++) begin
            we       = 1'($urandom_range(0, 1));
            rd_addr  = 5'($urandom);
            rd_data  = $urandom;
            rs1_addr = ($urandom_range(0, 3) == 0) ? rd_addr : 5'($urandom);
            rs2_addr = ($urandom_range(0, 3) == 0) ? rd_addr : 5'($urandom);
            #2;
            check("rand_rs1", bus.rs1_data, exp_rd(rs1_addr));
            check("rand_rs2", bus.rs2_data, exp_rd(rs2_addr));
            tick();
            check_echo("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
